seg_display_scanner: RTL and testbench
======================================

Name: seg_display_scanner

Overview:
Parameterised multiplexed seven-segment display driver. It scans NUM_DIGITS hex digits at a programmable per-digit dwell and supports per-digit decimal points, per-digit enables, leading-zero blanking and PWM brightness. The displayed value is frame-coherent. It sits between CPU-visible display registers and the board's anode/cathode pins.

Parameters:
NUM_DIGITS, 8, number of digits/anodes (1..16)
DIV_LOG2, 4, log2 of clock cycles per digit slot (slot length 2^DIV_LOG2)
DUTY_BITS, 3, brightness resolution; must satisfy 1 <= DUTY_BITS <= DIV_LOG2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
number  in  4*NUM_DIGITS  hex value; nibble i drives digit i (digit 0 = rightmost)
dp  in  NUM_DIGITS  decimal point per digit, active-high
digit_en  in  NUM_DIGITS  per-digit enable, active-high
blank_lz  in  1  enable leading-zero blanking
brightness  in  DUTY_BITS  on-time level; all-ones = 100%
anodes  out  NUM_DIGITS  AN[NUM_DIGITS-1:0], active-low
cathodes  out  8  {CA,CB,CC,CD,CE,CF,CG,DP}, active-low
frame_start  out  1  one-cycle pulse coincident with output of slot 0, phase 0

Behaviour:
- One clock (clk). Reset is synchronous and active-high on port reset.
- State: phase counter pre_cnt (DIV_LOG2 bits), slot counter (0..NUM_DIGITS-1), shadow_num, shadow_dp.
- Reset: pre_cnt=0, slot=0, shadows=0, anodes=all 1, cathodes=8'hFF, frame_start=0. Reset mid-scan aborts immediately; the next cycle shows reset values.
- Counting: pre_cnt increments every cycle and wraps. On wrap, slot increments. slot wraps from NUM_DIGITS-1 to 0, including non-power-of-2 counts.
- All outputs are registered. In the k-th rising edge after reset deasserts (k=1,2,...), outputs reflect slot = ((k-1)>>DIV_LOG2) mod NUM_DIGITS and phase = (k-1) mod 2^DIV_LOG2.
- Shadow load: on each edge that produces slot 0 / phase 0 output, shadow_num<=number and shadow_dp<=dp. Cathodes on that edge already use the newly sampled value. number/dp changes at other times are invisible until the next frame.
- digit_en, blank_lz and brightness are live (not shadowed) and take effect on the next edge.
- Anode: anodes[slot]=0 iff digit_en[slot]=1 and pre_cnt[DIV_LOG2-1 -: DUTY_BITS] <= brightness. All other anode bits are 1. At most one anode is low at any time.
- Glyphs, cathodes[7:1] from nibble n, shown as the 8-bit value with DP off: 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 B:C1 C:63 D:85 E:61 F:71.
- cathodes[0] = ~shadow_dp[slot].
- Leading-zero blanking: digit i (i>0) is blanked iff blank_lz=1 and shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- A blanked digit drives cathodes[7:1]=7'h7F. Its DP is still driven and its anode still follows the enable/PWM rules.
- A disabled digit still consumes its slot time; the scan rate is independent of digit_en.
- frame_start=1 only on the slot 0 / phase 0 output cycle, regardless of digit_en[0]. Period is NUM_DIGITS*2^DIV_LOG2 cycles.

Test Plan:
Bench parameters: NUM_DIGITS=4, DIV_LOG2=2, DUTY_BITS=2.
1. Reset held 3 cycles with arbitrary inputs -> anodes=4'hF, cathodes=8'hFF, frame_start=0 on every cycle.
2. number=16'h1234, dp=0, digit_en=4'hF, brightness=3, blank_lz=0 -> per 4-cycle slot: anodes 1110/cath 99, 1101/0D, 1011/25, 0111/9F. frame_start pulses every 16 cycles.
3. number=16'h0050, blank_lz=1 -> slot3 and slot2 cathodes FF, slot1 49, slot0 03. With blank_lz=0, slot3 shows 03.
4. brightness=0 -> active anode low on phase 0 only (1 of 4 cycles). brightness=1 -> low on phases 0-1. digit_en=4'b1011 -> anode 2 never low; slot timing unchanged.
5. Change number from 16'h1234 to 16'hABCD during slot 1 -> slots 1-3 of that frame still show 0D, 25, 9F. The next frame's slot 0 shows 85 in the same cycle as frame_start.
6. dp=4'b0010 -> cathodes[0]=0 only during slot 1. Assert reset during slot 2 -> reset values on the next cycle; the scan restarts at slot 0, phase 0 on the first edge after release.

Source files
------------

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner: time-slices NUM_DIGITS hex digits with
// PWM brightness, leading-zero blanking and frame-coherent value shadowing.
module seg_display_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_LOG2   = 4,
    parameter int DUTY_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [DUTY_BITS-1:0]    brightness,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [7:0]              cathodes,
    output logic                    frame_start
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    logic [DIV_LOG2-1:0]     pre_cnt_q, pre_cnt_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [4*NUM_DIGITS-1:0] shadow_num_q, shadow_num_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic [7:0]              cathodes_q, cathodes_d;
    logic                    frame_start_q, frame_start_d;

    logic                    frame_edge;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              sel_nib;
    logic                    sel_dp;
    logic                    sel_blank;
    logic                    duty_on;
    logic [6:0]              seg_pat;

    // Segments {CA..CG}, active-low; DP bit is appended separately.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h01;
            4'h1: g = 7'h4F;
            4'h2: g = 7'h12;
            4'h3: g = 7'h06;
            4'h4: g = 7'h4C;
            4'h5: g = 7'h24;
            4'h6: g = 7'h20;
            4'h7: g = 7'h0F;
            4'h8: g = 7'h00;
            4'h9: g = 7'h04;
            4'hA: g = 7'h08;
            4'hB: g = 7'h60;
            4'hC: g = 7'h31;
            4'hD: g = 7'h42;
            4'hE: g = 7'h30;
            default: g = 7'h38;
        endcase
        return g;
    endfunction

    always_comb begin
        int unsigned idx;
        idx       = 0;
        pre_cnt_d = pre_cnt_q + 1'b1;
        slot_d    = slot_q;
        if (pre_cnt_q == '1) begin
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        end

        // The frame's first output cycle already uses the freshly sampled value.
        frame_edge   = (pre_cnt_q == '0) && (slot_q == '0);
        shadow_num_d = frame_edge ? number : shadow_num_q;
        shadow_dp_d  = frame_edge ? dp : shadow_dp_q;

        lz_run = 1'b1;
        blank  = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            idx    = NUM_DIGITS - 1 - j;
            lz_run = lz_run & (shadow_num_d[4*idx +: 4] == 4'h0);
            if (idx != 0) begin
                blank[idx] = blank_lz & lz_run;
            end
        end

        duty_on   = (pre_cnt_q[DIV_LOG2-1 -: DUTY_BITS] <= brightness);
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        anodes_d  = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                sel_nib     = shadow_num_d[4*i +: 4];
                sel_dp      = shadow_dp_d[i];
                sel_blank   = blank[i];
                anodes_d[i] = ~(digit_en[i] & duty_on);
            end
        end

        seg_pat       = glyph(sel_nib);
        cathodes_d    = {sel_blank ? 7'h7F : seg_pat, ~sel_dp};
        frame_start_d = frame_edge;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q     <= '0;
            slot_q        <= '0;
            shadow_num_q  <= '0;
            shadow_dp_q   <= '0;
            anodes_q      <= '1;
            cathodes_q    <= '1;
            frame_start_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            slot_q        <= slot_d;
            shadow_num_q  <= shadow_num_d;
            shadow_dp_q   <= shadow_dp_d;
            anodes_q      <= anodes_d;
            cathodes_q    <= cathodes_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anodes      = anodes_q;
    assign cathodes    = cathodes_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (4 digits, 4-cycle slots, 2-bit duty):
// per-cycle scoreboard against a reference model plus table-driven spot checks.
module tb_seg_display_scanner;

    localparam int ND = 4;
    localparam int DL = 2;
    localparam int DB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   number;
    logic [3:0]    dp;
    logic [3:0]    digit_en;
    logic          blank_lz;
    logic [1:0]    brightness;
    logic [3:0]    anodes;
    logic [7:0]    cathodes;
    logic          frame_start;

    seg_display_scanner #(
        .NUM_DIGITS(ND),
        .DIV_LOG2  (DL),
        .DUTY_BITS (DB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .number     (number),
        .dp         (dp),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .anodes     (anodes),
        .cathodes   (cathodes),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] cath;
        logic       fs;
    } exp_t;

    typedef struct {
        logic [15:0] num;
        logic [3:0]  dpv;
        logic [3:0]  en;
        logic        blz;
        logic [1:0]  br;
        int unsigned slot;
        logic [3:0]  an;
        logic [7:0]  cath;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    logic [7:0]  glyph_tab[16];
    int          n_assert = 0;
    int          n_fail   = 0;

    int unsigned cnt;
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    int unsigned last_slot, last_phase;
    logic        last_fs;

    // Reference model: predicts outputs for the coming edge, then compares after it.
    task automatic tick();
        exp_t        e;
        exp_t        got;
        int unsigned slot, phase;
        logic [7:0]  g;
        logic        blanked;
        if (reset) begin
            cnt   = 0;
            m_num = '0;
            m_dp  = '0;
            e.an  = 4'hF;
            e.cath = 8'hFF;
            e.fs  = 1'b0;
            slot  = 0;
            phase = 0;
        end else begin
            phase = cnt % 4;
            slot  = (cnt >> DL) % ND;
            cnt++;
            if (slot == 0 && phase == 0) begin
                m_num = number;
                m_dp  = dp;
            end
            g       = glyph_tab[m_num[slot*4 +: 4]];
            blanked = blank_lz && (slot > 0) && ((m_num >> (slot*4)) == 16'h0);
            e.cath  = {blanked ? 7'h7F : g[7:1], ~m_dp[slot]};
            e.an    = 4'hF;
            if (digit_en[slot] && ((phase >> (DL - DB)) <= int'(brightness)))
                e.an[slot] = 1'b0;
            e.fs = (slot == 0 && phase == 0);
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        last_slot  = slot;
        last_phase = phase;
        last_fs    = got.fs;
        n_assert++;
        if (anodes !== got.an || cathodes !== got.cath || frame_start !== got.fs) begin
            n_fail++;
            $display("FAIL sb t=%0t slot=%0d ph=%0d: got an=%h cath=%h fs=%b, want an=%h cath=%h fs=%b",
                     $time, slot, phase, anodes, cathodes, frame_start, got.an, got.cath, got.fs);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Advance to the next frame start, then on to phase 0 of the given slot.
    task automatic goto_slot(input int unsigned s);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (last_fs) ok = 1;
        end
        if (ok && s != 0) begin
            ok = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                tick();
                if (last_slot == s && last_phase == 0) ok = 1;
            end
        end
        check("goto_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        int lows;
        int period;
        bit seen;

        glyph_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

        vecs[0]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 0, 4'hE, 8'h99};
        vecs[1]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 1, 4'hD, 8'h0D};
        vecs[2]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 2, 4'hB, 8'h25};
        vecs[3]  = '{16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 3, 4'h7, 8'h9F};
        vecs[4]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 3, 4'h7, 8'hFF};
        vecs[5]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 2, 4'hB, 8'hFF};
        vecs[6]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 1, 4'hD, 8'h49};
        vecs[7]  = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 0, 4'hE, 8'h03};
        vecs[8]  = '{16'h0050, 4'h0, 4'hF, 1'b0, 2'd3, 3, 4'h7, 8'h03};
        vecs[9]  = '{16'h1234, 4'h2, 4'hF, 1'b0, 2'd3, 1, 4'hD, 8'h0C};
        vecs[10] = '{16'h1234, 4'h2, 4'hF, 1'b0, 2'd3, 2, 4'hB, 8'h25};
        vecs[11] = '{16'h0000, 4'h8, 4'hB, 1'b1, 2'd0, 2, 4'hF, 8'hFF};

        // Reset with arbitrary inputs
        reset      = 1'b1;
        number     = 16'hBEEF;
        dp         = 4'h5;
        digit_en   = 4'hA;
        blank_lz   = 1'b1;
        brightness = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_an", 32'(anodes), 32'hF);
            check("reset_cath", 32'(cathodes), 32'hFF);
            check("reset_fs", 32'(frame_start), 32'h0);
        end
        reset = 1'b0;

        foreach (vecs[v]) begin
            number     = vecs[v].num;
            dp         = vecs[v].dpv;
            digit_en   = vecs[v].en;
            blank_lz   = vecs[v].blz;
            brightness = vecs[v].br;
            goto_slot(vecs[v].slot);
            check($sformatf("vec%0d_an", v), 32'(anodes), 32'(vecs[v].an));
            check($sformatf("vec%0d_cath", v), 32'(cathodes), 32'(vecs[v].cath));
        end

        // frame_start period
        number = 16'h1234; dp = 4'h0; digit_en = 4'hF; blank_lz = 1'b0; brightness = 2'd3;
        goto_slot(0);
        period = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            period++;
            if (frame_start === 1'b1) seen = 1;
        end
        check("fs_period", 32'(period), 32'd16);

        // PWM on-time per slot
        for (int b = 0; b < 2; b++) begin
            brightness = 2'(b);
            goto_slot(1);
            lows = (anodes[1] === 1'b0) ? 1 : 0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (anodes[1] === 1'b0) lows++;
            end
            check($sformatf("pwm_b%0d", b), 32'(lows), 32'(b + 1));
        end

        // Mid-frame number change is deferred to the next frame
        brightness = 2'd3;
        number = 16'h1234;
        goto_slot(1);
        number = 16'hABCD;
        check("hold_s1", 32'(cathodes), 32'h0D);
        for (int i = 0; i < 4; i++) tick();
        check("hold_s2", 32'(cathodes), 32'h25);
        for (int i = 0; i < 4; i++) tick();
        check("hold_s3", 32'(cathodes), 32'h9F);
        for (int i = 0; i < 4; i++) tick();
        check("new_fs", 32'(frame_start), 32'h1);
        check("new_s0", 32'(cathodes), 32'h85);

        // Reset mid-scan, then restart from slot 0 / phase 0
        number = 16'h1234;
        dp = 4'b0010;
        goto_slot(2);
        tick();
        reset = 1'b1;
        tick();
        check("midrst_an", 32'(anodes), 32'hF);
        check("midrst_cath", 32'(cathodes), 32'hFF);
        check("midrst_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;
        tick();
        check("restart_fs", 32'(frame_start), 32'h1);
        check("restart_an", 32'(anodes), 32'hE);
        check("restart_cath", 32'(cathodes), 32'h99);
        for (int i = 0; i < 20; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
